// File: rtl/scan_timer_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// scan_timer_arbiter_pkg
// Shared definitions for the scan clock timer arbiter:
//   - ARB_* arbiter state encodings and ARB_STATE_WIDTH (debug readback width)
//   - NUM_REQ requester count (0 = scan executor, 1 = RTI/test sequencer)
//   - TIMER_SCAN_* states of the scan clock timer this arbiter fronts
//   - onehot_idx(): index of a one-hot requester vector
// -----------------------------------------------------------------------------
package scan_timer_arbiter_pkg;

  localparam int ARB_STATE_WIDTH = 2;
  localparam int NUM_REQ         = 2;

  typedef enum logic [ARB_STATE_WIDTH-1:0] {
    ARB_IDLE    = 2'd0,
    ARB_START   = 2'd1,
    ARB_WAIT    = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    TIMER_SCAN_IDLE  = 2'd0,
    TIMER_SCAN_COUNT = 2'd1,
    TIMER_SCAN_DONE  = 2'd2
  } timer_scan_state_t;

  // With two requesters a one-hot vector's index is simply its upper bit.
  function automatic logic onehot_idx(input logic [NUM_REQ-1:0] onehot);
    return onehot[1];
  endfunction

endpackage

// File: rtl/scan_timer_arb_select.sv
// -----------------------------------------------------------------------------
// scan_timer_arb_select
// Combinational winner selection between the two timer requesters.
//   req     in   pending requests, one bit per requester
//   pointer in   requester that wins when both requests are high
//   winner  out  one-hot winner, all zero when nothing is requested
// -----------------------------------------------------------------------------
module scan_timer_arb_select
  import scan_timer_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               pointer,
  output logic [NUM_REQ-1:0] winner
);

  always_comb begin
    winner = '0;
    if (req[0] && req[1]) begin
      winner[pointer] = 1'b1;
    end else if (req[0]) begin
      winner[0] = 1'b1;
    end else if (req[1]) begin
      winner[1] = 1'b1;
    end
  end

endmodule

// File: rtl/scan_timer_arbiter.sv
// -----------------------------------------------------------------------------
// scan_timer_arbiter
// Shares one scan clock timer between the scan executor (requester 0) and the
// RTI/test sequencer (requester 1). A requester holds req high, the arbiter
// grants the timer, loads its delay byte, pulses timer_start, waits for
// timer_done, acks the owner and releases once the owner drops req.
//
// Ports
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   reset        in   synchronous active-high reset, same effect as reset_n
//   abort        in   synchronous abort of the current wait
//   req[1:0]     in   level wait requests (4-phase handshake)
//   delay0/1     in   delay byte per requester (hi nibble mult, lo nibble exp)
//   ack[1:0]     out  one-cycle done pulse to the owner
//   grant[1:0]   out  one-hot timer owner, zero when free
//   timer_delay  out  delay byte presented to the timer
//   timer_start  out  one-cycle timer start pulse
//   timer_done   in   one-cycle done pulse from the timer
//   timer_reset  out  synchronous reset to the timer
//   arb_state    out  current arbiter state for debug readback
//
// Configuration
//   SCAN_TIMER_RR_EN  defined: round-robin tie break; undefined: requester 0
//                     always wins a tie and no pointer register exists.
// -----------------------------------------------------------------------------
module scan_timer_arbiter
  import scan_timer_arbiter_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       reset,
  input  logic                       abort,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [7:0]                 delay0,
  input  logic [7:0]                 delay1,
  output logic [NUM_REQ-1:0]         ack,
  output logic [NUM_REQ-1:0]         grant,
  output logic [7:0]                 timer_delay,
  output logic                       timer_start,
  input  logic                       timer_done,
  output logic                       timer_reset,
  output logic [ARB_STATE_WIDTH-1:0] arb_state
);

  arb_state_t         state_q;
  arb_state_t         state_d;
  logic [NUM_REQ-1:0] grant_d;
  logic [NUM_REQ-1:0] ack_d;
  logic [7:0]         delay_d;
  logic               start_d;
  logic [NUM_REQ-1:0] winner;
  logic               pointer;
  logic               abort_hit;
  logic               grant_event;

  // Abort only matters while the timer is owned; in ARB_IDLE it is a no-op.
  assign abort_hit   = abort && (state_q != ARB_IDLE);
  assign grant_event = (state_q == ARB_IDLE) && (|req);

  scan_timer_arb_select u_select (
    .req     (req),
    .pointer (pointer),
    .winner  (winner)
  );

`ifdef SCAN_TIMER_RR_EN
  // The pointer names the requester that wins the next tie, i.e. the one that
  // did not own the timer last. Its reset value 0 lets requester 0 win first.
  logic pointer_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pointer_q <= 1'b0;
    end else if (reset) begin
      pointer_q <= 1'b0;
    end else if (grant_event) begin
      pointer_q <= ~onehot_idx(winner);
    end
  end

  assign pointer = pointer_q;
`else
  assign pointer = 1'b0;
`endif

  // NOTE: every signal gets a default before the case so that no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    grant_d = grant;
    delay_d = timer_delay;
    start_d = 1'b0;
    ack_d   = '0;
    if (abort_hit) begin
      // Abort beats a coincident timer_done: no ack, timer is released.
      state_d = ARB_IDLE;
      grant_d = '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (grant_event) begin
            grant_d = winner;
            delay_d = onehot_idx(winner) ? delay1 : delay0;
            state_d = ARB_START;
          end
        end
        ARB_START: begin
          // Registered, so the pulse appears one cycle after ARB_START is
          // entered: two cycles after the request reached ARB_IDLE.
          start_d = 1'b1;
          state_d = ARB_WAIT;
        end
        ARB_WAIT: begin
          if (timer_done) begin
            ack_d   = grant;
            state_d = ARB_RELEASE;
          end
        end
        ARB_RELEASE: begin
          if (!(|(req & grant))) begin
            grant_d = '0;
            state_d = ARB_IDLE;
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ARB_IDLE;
      grant       <= '0;
      ack         <= '0;
      timer_delay <= 8'h00;
      timer_start <= 1'b0;
    end else if (reset) begin
      state_q     <= ARB_IDLE;
      grant       <= '0;
      ack         <= '0;
      timer_delay <= 8'h00;
      timer_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant       <= grant_d;
      ack         <= ack_d;
      timer_delay <= delay_d;
      timer_start <= start_d;
    end
  end

  // The timer shares reset_n, so it only needs an explicit reset for the
  // synchronous reset and for an abort of a running wait.
  assign timer_reset = reset_n && (reset || abort_hit);
  assign arb_state   = state_q;

endmodule
